// File: rtl/dualport_ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
package dualport_ram_pkg;

   typedef enum logic [0:0] {StClear, StRun} state_e;

   localparam int unsigned RDW_OLD = 0;
   localparam int unsigned RDW_NEW = 1;

   // Even-parity bit of one byte lane; callers zero-extend the lane to 64 bits.
   function automatic logic byte_parity(input logic [63:0] lane);
      return ^lane;
   endfunction

endpackage

// File: rtl/dualport_ram_be_if.sv
// One access port of the dual-port RAM: request fields from the master,
// read response from the slave.
interface dualport_ram_be_if #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned BYTE_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 3
);
   localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

   logic                     en;
   logic                     we;
   logic [NB-1:0]            be;
   logic [ADDRESS_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0]    wdata;
   logic [DATA_WIDTH-1:0]    rdata;
   logic                     rvalid;
   logic                     parity_err;

   modport master (
      output en, we, be, addr, wdata,
      input  rdata, rvalid, parity_err
   );

   modport slave (
      input  en, we, be, addr, wdata,
      output rdata, rvalid, parity_err
   );

endinterface

// File: rtl/dualport_ram_rdpipe.sv
// Per-port read pipeline: cross-port merge, optional parity check, and one or
// two output register stages. Parity checking follows DUALPORT_RAM_PARITY_EN.
module dualport_ram_rdpipe
   import dualport_ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned BYTE_WIDTH   = 8,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned RDW_MODE     = RDW_OLD,
   localparam int unsigned NB          = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  rd_req_i,
   input  logic [DATA_WIDTH-1:0] old_word_i,
   input  logic [NB-1:0]         merge_be_i,
   input  logic [DATA_WIDTH-1:0] merge_data_i,
`ifdef DUALPORT_RAM_PARITY_EN
   input  logic [NB-1:0]         old_par_i,
`endif
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rvalid_o,
   output logic                  parity_err_o
);

   logic [DATA_WIDTH-1:0] word;
   logic                  chk_err;
   logic [DATA_WIDTH-1:0] d1_q, d1_d, d2_q, d2_d;
   logic                  v1_q, v1_d, v2_q, v2_d;
   logic                  e1_q, e1_d, e2_q, e2_d;

   // merge_be_i is already qualified by the other port writing this address.
   always_comb begin
      word = old_word_i;
      if (RDW_MODE == RDW_NEW) begin
         for (int i = 0; i < NB; i++) begin
            if (merge_be_i[i]) begin
               word[i*BYTE_WIDTH +: BYTE_WIDTH] = merge_data_i[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

`ifdef DUALPORT_RAM_PARITY_EN
   logic [NB-1:0] word_par;

   always_comb begin
      word_par = old_par_i;
      chk_err  = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if ((RDW_MODE == RDW_NEW) && merge_be_i[i]) begin
            word_par[i] = byte_parity(64'(merge_data_i[i*BYTE_WIDTH +: BYTE_WIDTH]));
         end
         if (byte_parity(64'(word[i*BYTE_WIDTH +: BYTE_WIDTH])) != word_par[i]) begin
            chk_err = 1'b1;
         end
      end
   end
`else
   assign chk_err = 1'b0;
`endif

   always_comb begin
      d1_d = d1_q;
      v1_d = rd_req_i;
      e1_d = 1'b0;
      if (rd_req_i) begin
         d1_d = word;
         e1_d = chk_err;
      end
      d2_d = d2_q;
      v2_d = v1_q;
      e2_d = 1'b0;
      if (v1_q) begin
         d2_d = d1_q;
         e2_d = e1_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d1_q <= '0;
         v1_q <= 1'b0;
         e1_q <= 1'b0;
         d2_q <= '0;
         v2_q <= 1'b0;
         e2_q <= 1'b0;
      end else begin
         d1_q <= d1_d;
         v1_q <= v1_d;
         e1_q <= e1_d;
         d2_q <= d2_d;
         v2_q <= v2_d;
         e2_q <= e2_d;
      end
   end

   assign rdata_o      = (READ_LATENCY == 2) ? d2_q : d1_q;
   assign rvalid_o     = (READ_LATENCY == 2) ? v2_q : v1_q;
   assign parity_err_o = (READ_LATENCY == 2) ? e2_q : e1_q;

endmodule

// File: rtl/dualport_ram_be.sv
// True dual-port RAM with byte enables, post-reset clear FSM and write-write
// collision flag. Define DUALPORT_RAM_PARITY_EN to store per-lane parity.
module dualport_ram_be
   import dualport_ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned BYTE_WIDTH     = 8,
   parameter int unsigned ADDRESS_WIDTH  = 3,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned RDW_MODE       = RDW_OLD,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic             clk,
   input  logic             rst,
   output logic             init_done,
   output logic             collision,
   dualport_ram_be_if.slave port_a,
   dualport_ram_be_if.slave port_b
);

   localparam int unsigned NB       = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned RAM_SIZE = 1 << ADDRESS_WIDTH;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] clear_addr_q, clear_addr_d;
   logic                     init_done_q, init_done_d;
   logic                     collision_q, collision_d;

   logic [DATA_WIDTH-1:0] mem_q [RAM_SIZE];
   logic [DATA_WIDTH-1:0] mem_d [RAM_SIZE];

   logic          active, wr_a, wr_b, rd_a, rd_b;
   logic [NB-1:0] merge_be_a, merge_be_b;

   // Requests arriving while clearing or in reset are dropped outright.
   assign active = (state_q == StRun) && !rst;
   assign wr_a   = active && port_a.en && port_a.we;
   assign wr_b   = active && port_b.en && port_b.we;
   assign rd_a   = active && port_a.en && !port_a.we;
   assign rd_b   = active && port_b.en && !port_b.we;

   assign merge_be_a = (wr_b && (port_b.addr == port_a.addr)) ? port_b.be : '0;
   assign merge_be_b = (wr_a && (port_a.addr == port_b.addr)) ? port_a.be : '0;

   always_comb begin
      state_d      = state_q;
      clear_addr_d = clear_addr_q;
      init_done_d  = init_done_q;
      case (state_q)
         StClear: begin
            clear_addr_d = clear_addr_q + 1'b1;
            if (clear_addr_q == '1) begin
               state_d     = StRun;
               init_done_d = 1'b1;
            end
         end
         StRun: init_done_d = 1'b1;
      endcase
      collision_d = wr_a && wr_b && (port_a.addr == port_b.addr) && (|(port_a.be & port_b.be));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
         clear_addr_q <= '0;
         init_done_q  <= 1'b0;
         collision_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         clear_addr_q <= clear_addr_d;
         init_done_q  <= init_done_d;
         collision_q  <= collision_d;
      end
   end

   // B is applied first so that A overwrites it on shared lanes.
   always_comb begin
      mem_d = mem_q;
      if (state_q == StClear) begin
         mem_d[clear_addr_q] = '0;
      end
      for (int i = 0; i < NB; i++) begin
         if (wr_b && port_b.be[i]) begin
            mem_d[port_b.addr][i*BYTE_WIDTH +: BYTE_WIDTH] = port_b.wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
         if (wr_a && port_a.be[i]) begin
            mem_d[port_a.addr][i*BYTE_WIDTH +: BYTE_WIDTH] = port_a.wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef DUALPORT_RAM_PARITY_EN
   logic [NB-1:0] par_q [RAM_SIZE];
   logic [NB-1:0] par_d [RAM_SIZE];

   always_comb begin
      par_d = par_q;
      if (state_q == StClear) begin
         par_d[clear_addr_q] = '0;
      end
      for (int i = 0; i < NB; i++) begin
         if (wr_b && port_b.be[i]) begin
            par_d[port_b.addr][i] = byte_parity(64'(port_b.wdata[i*BYTE_WIDTH +: BYTE_WIDTH]));
         end
         if (wr_a && port_a.be[i]) begin
            par_d[port_a.addr][i] = byte_parity(64'(port_a.wdata[i*BYTE_WIDTH +: BYTE_WIDTH]));
         end
      end
   end

   always_ff @(posedge clk) begin
      par_q <= par_d;
   end
`endif

   dualport_ram_rdpipe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .BYTE_WIDTH  (BYTE_WIDTH),
      .READ_LATENCY(READ_LATENCY),
      .RDW_MODE    (RDW_MODE)
   ) u_rdpipe_a (
      .clk_i       (clk),
      .rst_i       (rst),
      .rd_req_i    (rd_a),
      .old_word_i  (mem_q[port_a.addr]),
      .merge_be_i  (merge_be_a),
      .merge_data_i(port_b.wdata),
`ifdef DUALPORT_RAM_PARITY_EN
      .old_par_i   (par_q[port_a.addr]),
`endif
      .rdata_o     (port_a.rdata),
      .rvalid_o    (port_a.rvalid),
      .parity_err_o(port_a.parity_err)
   );

   dualport_ram_rdpipe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .BYTE_WIDTH  (BYTE_WIDTH),
      .READ_LATENCY(READ_LATENCY),
      .RDW_MODE    (RDW_MODE)
   ) u_rdpipe_b (
      .clk_i       (clk),
      .rst_i       (rst),
      .rd_req_i    (rd_b),
      .old_word_i  (mem_q[port_b.addr]),
      .merge_be_i  (merge_be_b),
      .merge_data_i(port_a.wdata),
`ifdef DUALPORT_RAM_PARITY_EN
      .old_par_i   (par_q[port_b.addr]),
`endif
      .rdata_o     (port_b.rdata),
      .rvalid_o    (port_b.rvalid),
      .parity_err_o(port_b.parity_err)
   );

   assign init_done = init_done_q;
   assign collision = collision_q;

endmodule

// File: tb/tb_dualport_ram_be.sv
// Directed bench: dut0 is the default build (8-bit, latency 1, old-data RDW);
// dut1 is 16-bit with two byte lanes, latency 2 and merged-data RDW.
module tb_dualport_ram_be;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic init_done0, collision0, init_done1, collision1;
   int   n_vec = 0;
   int   n_err = 0;

   dualport_ram_be_if #(.DATA_WIDTH(8),  .BYTE_WIDTH(8), .ADDRESS_WIDTH(3)) a0 ();
   dualport_ram_be_if #(.DATA_WIDTH(8),  .BYTE_WIDTH(8), .ADDRESS_WIDTH(3)) b0 ();
   dualport_ram_be_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDRESS_WIDTH(3)) a1 ();
   dualport_ram_be_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDRESS_WIDTH(3)) b1 ();

   dualport_ram_be #(
      .DATA_WIDTH(8), .BYTE_WIDTH(8), .ADDRESS_WIDTH(3),
      .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
   ) u_dut0 (
      .clk(clk), .rst(rst), .init_done(init_done0), .collision(collision0),
      .port_a(a0), .port_b(b0)
   );

   dualport_ram_be #(
      .DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDRESS_WIDTH(3),
      .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
   ) u_dut1 (
      .clk(clk), .rst(rst), .init_done(init_done1), .collision(collision1),
      .port_a(a1), .port_b(b1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drv_a0(input logic en, input logic we, input logic be,
                         input logic [2:0] addr, input logic [7:0] wd);
      a0.en = en; a0.we = we; a0.be = be; a0.addr = addr; a0.wdata = wd;
   endtask

   task automatic drv_b0(input logic en, input logic we, input logic be,
                         input logic [2:0] addr, input logic [7:0] wd);
      b0.en = en; b0.we = we; b0.be = be; b0.addr = addr; b0.wdata = wd;
   endtask

   task automatic drv_a1(input logic en, input logic we, input logic [1:0] be,
                         input logic [2:0] addr, input logic [15:0] wd);
      a1.en = en; a1.we = we; a1.be = be; a1.addr = addr; a1.wdata = wd;
   endtask

   task automatic drv_b1(input logic en, input logic we, input logic [1:0] be,
                         input logic [2:0] addr, input logic [15:0] wd);
      b1.en = en; b1.we = we; b1.be = be; b1.addr = addr; b1.wdata = wd;
   endtask

   task automatic idle();
      drv_a0(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      drv_b0(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      drv_a1(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000);
      drv_b1(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      check("rst_init_done0", 32'(init_done0), 32'h0);
      check("rst_init_done1", 32'(init_done1), 32'h0);
      check("rst_rvalid_a0", 32'(a0.rvalid), 32'h0);
      check("rst_rdata_a1", 32'(a1.rdata), 32'h0);
      check("rst_collision1", 32'(collision1), 32'h0);
      check("rst_parity_b0", 32'(b0.parity_err), 32'h0);

      // Clear after reset; requests during the clear are dropped.
      rst = 1'b0;
      repeat (4) tick();
      drv_a0(1'b1, 1'b1, 1'b1, 3'd0, 8'h5A);
      drv_b0(1'b1, 1'b0, 1'b0, 3'd1, 8'h00);
      drv_b1(1'b1, 1'b0, 2'b00, 3'd1, 16'h0000);
      tick();
      check("clr_drop_rvalid_b0", 32'(b0.rvalid), 32'h0);
      idle();
      tick();
      check("clr_drop_rvalid_b1", 32'(b1.rvalid), 32'h0);
      tick();
      check("clr_init_done_7", 32'(init_done0), 32'h0);
      tick();
      check("clr_init_done0_8", 32'(init_done0), 32'h1);
      check("clr_init_done1_8", 32'(init_done1), 32'h1);

      for (int i = 0; i < 8; i++) begin
         drv_a0(1'b1, 1'b0, 1'b0, 3'(i), 8'h00);
         tick();
         check("clr_read_rvalid", 32'(a0.rvalid), 32'h1);
         check("clr_read_rdata", 32'(a0.rdata), 32'h00);
      end
      idle();
      tick();
      check("rvalid_pulse_a0", 32'(a0.rvalid), 32'h0);

      // Cross-port read during write at address 5.
      drv_a0(1'b1, 1'b1, 1'b1, 3'd5, 8'h12);
      drv_a1(1'b1, 1'b1, 2'b11, 3'd5, 16'h1212);
      tick();
      drv_a0(1'b1, 1'b1, 1'b1, 3'd5, 8'h34);
      drv_b0(1'b1, 1'b0, 1'b0, 3'd5, 8'h00);
      drv_a1(1'b1, 1'b1, 2'b01, 3'd5, 16'h3434);
      drv_b1(1'b1, 1'b0, 2'b00, 3'd5, 16'h0000);
      tick();
      check("rdw_old_rvalid_b0", 32'(b0.rvalid), 32'h1);
      check("rdw_old_rdata_b0", 32'(b0.rdata), 32'h12);
      idle();
      tick();
      check("rdw_new_rvalid_b1", 32'(b1.rvalid), 32'h1);
      check("rdw_new_rdata_b1", 32'(b1.rdata), 32'h1234);
      check("rdw_new_parity_b1", 32'(b1.parity_err), 32'h0);
      drv_b0(1'b1, 1'b0, 1'b0, 3'd5, 8'h00);
      tick();
      check("rdw_after_rdata_b0", 32'(b0.rdata), 32'h34);
      idle();

      // Byte-lane writes on the 16-bit instance.
      drv_a1(1'b1, 1'b1, 2'b11, 3'd0, 16'hAABB);
      tick();
      check("wr_no_rvalid_a1", 32'(a1.rvalid), 32'h0);
      drv_a1(1'b1, 1'b1, 2'b01, 3'd0, 16'h1122);
      tick();
      drv_a1(1'b1, 1'b1, 2'b00, 3'd0, 16'hFFFF);
      tick();
      drv_a1(1'b1, 1'b0, 2'b00, 3'd0, 16'h0000);
      tick();
      idle();
      check("be_lat_p1_rvalid", 32'(a1.rvalid), 32'h0);
      tick();
      check("be_rvalid_a1", 32'(a1.rvalid), 32'h1);
      check("be_rdata_a1", 32'(a1.rdata), 32'hAA22);

      // Back-to-back reads with two-cycle latency.
      drv_b1(1'b1, 1'b1, 2'b11, 3'd1, 16'h0101);
      tick();
      drv_b1(1'b1, 1'b1, 2'b11, 3'd2, 16'h0202);
      tick();
      drv_b1(1'b1, 1'b1, 2'b11, 3'd3, 16'h0303);
      tick();
      idle();
      drv_a1(1'b1, 1'b0, 2'b00, 3'd1, 16'h0000);
      tick();
      check("lat_p1_rvalid", 32'(a1.rvalid), 32'h0);
      drv_a1(1'b1, 1'b0, 2'b00, 3'd2, 16'h0000);
      tick();
      check("lat_p2_rvalid", 32'(a1.rvalid), 32'h1);
      check("lat_p2_rdata", 32'(a1.rdata), 32'h0101);
      drv_a1(1'b1, 1'b0, 2'b00, 3'd3, 16'h0000);
      tick();
      check("lat_p3_rdata", 32'(a1.rdata), 32'h0202);
      idle();
      tick();
      check("lat_p4_rvalid", 32'(a1.rvalid), 32'h1);
      check("lat_p4_rdata", 32'(a1.rdata), 32'h0303);
      tick();
      check("lat_p5_rvalid", 32'(a1.rvalid), 32'h0);
      check("lat_hold_rdata", 32'(a1.rdata), 32'h0303);

      // Write-write collisions.
      drv_a1(1'b1, 1'b1, 2'b01, 3'd2, 16'hAAAA);
      drv_b1(1'b1, 1'b1, 2'b11, 3'd2, 16'hBBBB);
      drv_a0(1'b1, 1'b1, 1'b1, 3'd3, 8'hAA);
      drv_b0(1'b1, 1'b1, 1'b1, 3'd3, 8'hBB);
      tick();
      check("coll_overlap1", 32'(collision1), 32'h1);
      check("coll_overlap0", 32'(collision0), 32'h1);
      drv_a1(1'b1, 1'b1, 2'b01, 3'd4, 16'h1111);
      drv_b1(1'b1, 1'b1, 2'b10, 3'd4, 16'h2222);
      drv_a0(1'b1, 1'b1, 1'b1, 3'd6, 8'h66);
      drv_b0(1'b1, 1'b1, 1'b1, 3'd7, 8'h77);
      tick();
      check("coll_disjoint_be1", 32'(collision1), 32'h0);
      check("coll_diff_addr0", 32'(collision0), 32'h0);
      idle();
      drv_a1(1'b1, 1'b1, 2'b11, 3'd6, 16'h6666);
      drv_b1(1'b1, 1'b1, 2'b11, 3'd7, 16'h7777);
      tick();
      check("coll_diff_addr1", 32'(collision1), 32'h0);
      idle();
      drv_a1(1'b1, 1'b0, 2'b00, 3'd2, 16'h0000);
      drv_b1(1'b1, 1'b0, 2'b00, 3'd4, 16'h0000);
      drv_a0(1'b1, 1'b0, 1'b0, 3'd3, 8'h00);
      drv_b0(1'b1, 1'b0, 1'b0, 3'd7, 8'h00);
      tick();
      idle();
      check("coll_mem_a0", 32'(a0.rdata), 32'hAA);
      check("coll_mem_b0", 32'(b0.rdata), 32'h77);
      tick();
      check("coll_mem_a1", 32'(a1.rdata), 32'hBBAA);
      check("coll_mem_b1", 32'(b1.rdata), 32'h2211);

      // Reset in the middle of the clear restarts it from address 0.
      rst = 1'b1;
      tick();
      check("rst2_init_done0", 32'(init_done0), 32'h0);
      check("rst2_collision1", 32'(collision1), 32'h0);
      rst = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drv_a0(1'b1, 1'b0, 1'b0, 3'd3, 8'h00);
      drv_a1(1'b1, 1'b1, 2'b11, 3'd0, 16'hFFFF);
      tick();
      check("mid_drop_rvalid_a0", 32'(a0.rvalid), 32'h0);
      idle();
      repeat (6) tick();
      check("mid_init_done_7", 32'(init_done1), 32'h0);
      tick();
      check("mid_init_done0_8", 32'(init_done0), 32'h1);
      check("mid_init_done1_8", 32'(init_done1), 32'h1);
      drv_a0(1'b1, 1'b0, 1'b0, 3'd3, 8'h00);
      drv_b0(1'b1, 1'b0, 1'b0, 3'd5, 8'h00);
      drv_a1(1'b1, 1'b0, 2'b00, 3'd0, 16'h0000);
      drv_b1(1'b1, 1'b0, 2'b00, 3'd2, 16'h0000);
      tick();
      idle();
      check("mid_zero_a0", 32'(a0.rdata), 32'h00);
      check("mid_zero_b0", 32'(b0.rdata), 32'h00);
      tick();
      check("mid_zero_rvalid_a1", 32'(a1.rvalid), 32'h1);
      check("mid_zero_a1", 32'(a1.rdata), 32'h0000);
      check("mid_zero_b1", 32'(b1.rdata), 32'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dualport_ram_be.md
Name: dualport_ram_be

Overview:
Parametrised true dual-port synchronous RAM with per-byte write enables, selectable read latency, and a defined cross-port read-during-write policy. Detects write-write collisions, and an FSM zero-clears memory after reset. Successor to the simple dual-port RAM. Serves as the shared buffer between the host-interface side and the DSP/control side of the LFXP2 fabric. External ports use separate wdata/rdata buses; there are no internal tristates.

Parameters:
DATA_WIDTH, 8, word width; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, bits per byte lane; NB = DATA_WIDTH/BYTE_WIDTH
ADDRESS_WIDTH, 3, address bits; RAM_SIZE = 1<<ADDRESS_WIDTH words
READ_LATENCY, 1, read-data latency: 1 = array register only, 2 = extra output register
RDW_MODE, 0, cross-port read of a word being written: 0 = old data, 1 = new merged data
CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = skip the clear

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous reset, active-high
init_done  out  1  high once the array is usable
en_a / en_b  in  1  access request, one per port
we_a / we_b  in  1  1 = write, 0 = read (qualified by en)
be_a / be_b  in  NB  byte-lane write enables
addr_a / addr_b  in  ADDRESS_WIDTH  word address
wdata_a / wdata_b  in  DATA_WIDTH  write data
rdata_a / rdata_b  out  DATA_WIDTH  read data
rvalid_a / rvalid_b  out  1  one-cycle pulse, rdata valid
collision  out  1  one-cycle pulse on an overlapping write-write
parity_err_a / parity_err_b  out  1  parity mismatch flag, coincident with rvalid

Behaviour:
- Reset values (clk edge with rst=1): rdata_*=0, rvalid_*=0, collision=0, parity_err_*=0, init_done=0, clear_addr=0.
- FSM state after reset: CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- FSM CLEAR: writes 0 to memory[clear_addr] each cycle and increments clear_addr. After writing RAM_SIZE-1, moves to RUN and sets init_done=1 on the same edge. The clear therefore takes RAM_SIZE cycles.
- FSM RUN: terminal state; init_done stays 1. With CLEAR_ON_RESET=0, init_done rises on the first edge with rst=0.
- Requests in CLEAR: dropped, not queued. No memory change, no rvalid.
- Reset mid-clear: clear restarts from address 0.
- Read (en=1, we=0, RUN): rdata/rvalid appear READ_LATENCY cycles after the request edge. rdata holds its last value between reads. Back-to-back reads give one result per cycle.
- Write (en=1, we=1, RUN): lanes with be[i]=1 are updated at the edge; other lanes keep old data. be=0 makes no change. Writes never raise rvalid.
- Same-port reads see writes from earlier cycles.
- Cross-port write + read, same address, same cycle:
  - RDW_MODE=0: reader gets the pre-write word.
  - RDW_MODE=1: reader gets the merged word (written lanes new, others old).
- Write-write, same address, same cycle:
  - Per lane, A wins where be_a=1; B applies where be_b=1 and be_a=0.
  - collision pulses high one cycle later if (be_a & be_b) != 0.
  - Different addresses never collide.
- Addresses cover 0..RAM_SIZE-1 fully; there is no out-of-range case.

Optional Feature:
DUALPORT_RAM_PARITY_EN:
- Defined: one even-parity bit is stored per byte lane, computed on write, and CLEAR writes parity 0. On a read, every lane is rechecked. parity_err_x=1 with rvalid_x if any lane mismatches, otherwise 0.
- Undefined: no parity storage; parity_err_* tied to 0. The ports are always present.

Decomposition:
- Package dualport_ram_pkg: FSM state encoding (CLEAR, RUN); RDW_OLD=0 and RDW_NEW=1 constants; byte-parity function.
- Sub-module dualport_ram_rdpipe: per-port read pipeline covering the rdata/rvalid/parity_err registers, READ_LATENCY stage selection, and the RDW merge mux. Instantiated twice.
- The top level holds the array, the clear FSM and collision detection.

Test Plan:
- Reset then clear, defaults: init_done rises exactly 8 cycles after rst falls. A read of every address returns 0x00 with rvalid one cycle after each request.
- Byte-lane write, DATA_WIDTH=32: write 0xAABBCCDD with be=4'b1111, then 0x11223344 with be=4'b0101, then read → 0xAA22CC44.
- Read latency, READ_LATENCY=2: reads to addresses 1,2,3 on consecutive cycles → rvalid on cycles +2,+3,+4 with the matching data.
- RDW, mem[5]=0x12: A writes 0x34 to addr 5 while B reads addr 5 in the same cycle → B gets 0x12 with RDW_MODE=0 and 0x34 with RDW_MODE=1.
- Collision, DATA_WIDTH=16: A writes 0xAAAA be=2'b01 and B writes 0xBBBB be=2'b11 to addr 2 in the same cycle → mem[2]=0xBBAA, collision pulses once on the next cycle. Disjoint be or different addresses → no pulse.
- Reset mid-clear: assert rst at clear_addr=4, release → init_done takes 8 more cycles and the array reads all zeros. Requests issued during clear produce no rvalid.
